regfile_read_arbiter: RTL

//  Shares the single 32-way register-file read mux (Sel/Dout) among NREQ requesters.

---
 rtl/regfile_read_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NREQ requesters.
// Optional: define ZERO_REG_EN to force read data of register 0 to zero.
module regfile_read_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NREQ-1:0]     Req,
  input  logic [NREQ*AW-1:0]  Addr,
  output logic [NREQ-1:0]     Gnt,
  output logic                Busy,
  output logic [AW-1:0]       Sel,
  input  logic [DW-1:0]       Dout,
  output logic                RdValid,
  output logic [IDW-1:0]      RdId,
  output logic [DW-1:0]       RdData
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] win;
  logic           found;
  logic [IDW:0]   scan;
  logic [AW-1:0]  addr_arr [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_arr[i] = Addr[i*AW +: AW];
    end
  end

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) begin
        scan = scan - (IDW+1)'(NREQ);
      end
      if (!found && Req[scan[IDW-1:0]]) begin
        found = 1'b1;
        win   = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    Gnt       = '0;
    unique case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT: begin
        Gnt[id]   = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy    = (state != IDLE);
  assign RdValid = (state == RESP);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      ptr    <= '0;
      id     <= '0;
      Sel    <= '0;
      RdId   <= '0;
      RdData <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (found) begin
          Sel <= addr_arr[win];
          id  <= win;
        end
        GRANT: begin
          RdId <= id;
`ifdef ZERO_REG_EN
          RdData <= (Sel == '0) ? '0 : Dout;
`else
          RdData <= Dout;
`endif
        end
        RESP: ptr <= (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
